mmio_fabric: RTL



---
 rtl/mmio_pkg.sv | 16 +
 rtl/mmio_irq_ctrl.sv | 47 ++++
 rtl/mmio_fabric.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - shared encodings for the MMIO fabric
package mmio_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam int REG_IRQ_PENDING = 0;
    localparam int REG_IRQ_MASK    = 1;
    localparam int REG_STATUS      = 2;
    localparam int REG_LAST_ERR    = 3;

    localparam logic [7:0] UNMAPPED_DATA = 8'hFF;

endpackage

// File: rtl/mmio_irq_ctrl.sv
// rtl/mmio_irq_ctrl.sv - interrupt synchroniser, mask register and aggregation
module mmio_irq_ctrl #(
    parameter int NSLOTS = 8
) (
    input  logic              system_clk,
    input  logic              reset,
    input  logic [NSLOTS-1:0] slot_irq,
    input  logic              mask_we,
    input  logic [7:0]        mask_wdata,
    output logic [7:0]        pending,
    output logic [7:0]        mask,
    output logic              irq
);

    // At least 8 bits wide so the readable pending byte is always fully defined
    localparam int PW = (NSLOTS > 8) ? NSLOTS : 8;

    logic [PW-1:0] sync_q1;
    logic [PW-1:0] sync_q2;

    assign pending = sync_q2[7:0];

    // Two-flop synchroniser on the level interrupt requests
    always_ff @(posedge system_clk or posedge reset) begin
        if (reset) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= PW'(slot_irq);
            sync_q2 <= sync_q1;
        end
    end

    // Mask register written from the control slot; irq is the registered masked OR
    always_ff @(posedge system_clk or posedge reset) begin
        if (reset) begin
            mask <= '0;
            irq  <= 1'b0;
        end else begin
            if (mask_we) begin
                mask <= mask_wdata;
            end
            irq <= |(pending & mask);
        end
    end

endmodule

// File: rtl/mmio_fabric.sv
// rtl/mmio_fabric.sv - CPU register bus decoder with wait states, timeout and irq aggregation
module mmio_fabric
    import mmio_pkg::*;
#(
    parameter int          NSLOTS         = 8,
    parameter int          SLOT_AW        = 4,
    parameter int          REG_AW         = 8,
    parameter logic [31:0] HANDSHAKE_MASK = 32'd0,
    parameter int          TIMEOUT        = 255,
    parameter int          CTRL_SLOT      = (1 << SLOT_AW) - 1
) (
    input  logic                      system_clk,
    input  logic                      reset,
    input  logic                      re,
    input  logic                      we,
    input  logic [SLOT_AW+REG_AW-1:0] addr,
    input  logic [7:0]                data_write,
    output logic [7:0]                data_read,
    output logic                      busy,
    output logic                      bus_err,
    output logic                      irq,
    output logic [NSLOTS-1:0]         slot_sel,
    output logic [NSLOTS-1:0]         slot_re,
    output logic [NSLOTS-1:0]         slot_we,
    output logic [REG_AW-1:0]         slot_addr,
    output logic [7:0]                slot_wdata,
    input  logic [NSLOTS*8-1:0]       slot_rdata,
    input  logic [NSLOTS-1:0]         slot_stall,
    input  logic [NSLOTS-1:0]         slot_ack,
    input  logic [NSLOTS-1:0]         slot_irq
);

    localparam int                 ADDR_W   = SLOT_AW + REG_AW;
    localparam logic [SLOT_AW-1:0] CTRL_IDX = SLOT_AW'(CTRL_SLOT);
    localparam logic [15:0]        CNT_LAST = 16'(TIMEOUT - 1);

    logic [SLOT_AW-1:0] req_slot;
    logic [REG_AW-1:0]  req_reg;
    logic               req_any;
    logic               req_rd;
    logic               req_mapped;
    logic               req_ctrl;
    logic               req_hs;
    logic [NSLOTS-1:0]  req_hit;
    logic [7:0]         req_rdata;
    logic [7:0]         ctrl_rdata;

    state_t             state;
    logic [SLOT_AW-1:0] lat_slot;
    logic [REG_AW-1:0]  lat_reg;
    logic [7:0]         lat_wdata;
    logic               lat_rd;
    logic [15:0]        wait_cnt;
    logic [NSLOTS-1:0]  lat_hit;
    logic               lat_ack;
    logic [7:0]         lat_rdata;

    logic               status_to;
    logic [7:0]         last_err;
    logic               mask_we;
    logic [7:0]         irq_pending;
    logic [7:0]         irq_mask;

    // Stall is advisory only; completion is signalled solely by ack
    logic unused_stall;
    assign unused_stall = ^slot_stall;

    assign req_slot   = addr[ADDR_W-1:REG_AW];
    assign req_reg    = addr[REG_AW-1:0];
    assign req_any    = re | we;
    assign req_rd     = re & ~we;
    assign req_mapped = |req_hit;
    assign req_ctrl   = (req_slot == CTRL_IDX);
    assign bus_err    = status_to;
    assign mask_we    = (state == ST_IDLE) && we && req_ctrl
                        && (req_reg == REG_AW'(REG_IRQ_MASK));

    // Slot decode for the live request and for the latched wait-state access
    always_comb begin
        req_hit   = '0;
        req_hs    = 1'b0;
        req_rdata = '0;
        lat_hit   = '0;
        lat_ack   = 1'b0;
        lat_rdata = '0;
        for (int i = 0; i < NSLOTS; i++) begin
            if (req_slot == SLOT_AW'(i)) begin
                req_hit[i] = 1'b1;
                req_hs     = HANDSHAKE_MASK[i];
                req_rdata  = slot_rdata[8*i +: 8];
            end
            if (lat_slot == SLOT_AW'(i)) begin
                lat_hit[i] = 1'b1;
                lat_ack    = slot_ack[i];
                lat_rdata  = slot_rdata[8*i +: 8];
            end
        end
    end

    // Built-in control register read mux
    always_comb begin
        ctrl_rdata = '0;
        case (req_reg)
            REG_AW'(REG_IRQ_PENDING): ctrl_rdata = irq_pending;
            REG_AW'(REG_IRQ_MASK):    ctrl_rdata = irq_mask;
            REG_AW'(REG_STATUS):      ctrl_rdata = {7'd0, status_to};
            REG_AW'(REG_LAST_ERR):    ctrl_rdata = last_err;
            default:                  ctrl_rdata = '0;
        endcase
    end

    // Slot strobes: live decode in IDLE, held select with no strobes while waiting
    always_comb begin
        slot_sel   = '0;
        slot_re    = '0;
        slot_we    = '0;
        slot_addr  = '0;
        slot_wdata = '0;
        if (!reset) begin
            if (state == ST_IDLE) begin
                if (req_any && req_mapped) begin
                    slot_sel  = req_hit;
                    slot_re   = req_rd ? req_hit : '0;
                    slot_we   = we ? req_hit : '0;
                    slot_addr = req_reg;
                    if (we) begin
                        slot_wdata = data_write;
                    end
                end
            end else begin
                slot_sel   = lat_hit;
                slot_addr  = lat_reg;
                slot_wdata = lat_wdata;
            end
        end
    end

    // Access FSM: single-cycle completion, wait-state tracking, timeout and status
    always_ff @(posedge system_clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            data_read <= '0;
            status_to <= 1'b0;
            last_err  <= '0;
            lat_slot  <= '0;
            lat_reg   <= '0;
            lat_wdata <= '0;
            lat_rd    <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_any) begin
                        if (req_mapped && req_hs) begin
                            lat_slot  <= req_slot;
                            lat_reg   <= req_reg;
                            lat_wdata <= we ? data_write : 8'd0;
                            lat_rd    <= req_rd;
                            wait_cnt  <= '0;
                            busy      <= 1'b1;
                            state     <= ST_WAIT;
                        end else if (req_rd) begin
                            if (req_mapped) begin
                                data_read <= req_rdata;
                            end else if (req_ctrl) begin
                                data_read <= ctrl_rdata;
                            end else begin
                                data_read <= UNMAPPED_DATA;
                            end
                        end else if (req_ctrl && (req_reg == REG_AW'(REG_STATUS))
                                     && data_write[0]) begin
                            status_to <= 1'b0;
                        end
                    end
                end
                ST_WAIT: begin
                    if (lat_ack) begin
                        if (lat_rd) begin
                            data_read <= lat_rdata;
                        end
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (wait_cnt == CNT_LAST) begin
                        // Requests are ignored here, so a clear cannot race this set
                        if (lat_rd) begin
                            data_read <= UNMAPPED_DATA;
                        end
                        status_to <= 1'b1;
                        last_err  <= 8'(lat_slot);
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end else if (wait_cnt != 16'hFFFF) begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    mmio_irq_ctrl #(
        .NSLOTS (NSLOTS)
    ) u_irq_ctrl (
        .system_clk (system_clk),
        .reset      (reset),
        .slot_irq   (slot_irq),
        .mask_we    (mask_we),
        .mask_wdata (data_write),
        .pending    (irq_pending),
        .mask       (irq_mask),
        .irq        (irq)
    );

endmodule
